axis_boxcar_average: RTL and testbench
======================================

AXIS_BOXCAR_AVERAGE -- requirements
Module: axis_boxcar_average

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 2: AXIS data width in bytes.
REQ-002 SHALL have parameter CHANNELS, default 1: independent lanes packed in tdata; BUS_WIDTH*8 divisible by CHANNELS; lane width CW = BUS_WIDTH*8/CHANNELS, lane 0 at LSBs.
REQ-003 SHALL have parameter WEIGHT, default 8: window length in samples; power of two, 2..256; L = log2(WEIGHT).
REQ-004 SHALL have parameter SIGNED, default 0: 1 = lanes two's complement, 0 = unsigned.
REQ-005 SHALL have parameter CLEAR_ON_LAST, default 1: 1 = window restarts after a beat with tlast.
REQ-006 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port arst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports s_axis_tdata input BUS_WIDTH*8, s_axis_tvalid input 1, s_axis_tready output 1, s_axis_tlast input 1: sample input.
REQ-009 SHALL have ports m_axis_tdata output BUS_WIDTH*8, m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1: averaged output.
REQ-010 SHALL have port m_axis_tuser  output  1  1 = window full (WEIGHT real samples in average).

Function
REQ-011 SHALL assert s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational, single output register).
REQ-012 SHALL accept a beat when s_axis_tvalid & s_axis_tready; one output beat per accepted beat, latency 1 cycle.
REQ-013 SHALL hold m_axis_tdata/tlast/tuser stable while m_axis_tvalid & ~m_axis_tready; drop m_axis_tvalid after m_axis_tready with no new accept.
REQ-014 SHALL keep per lane a WEIGHT-entry history register array and a running sum of width CW+L (sign-extended when SIGNED=1).
REQ-015 SHALL on accept per lane: oldest = history[ptr] if count == WEIGHT else 0; sum_next = sum + new - oldest; history[ptr] = new; ptr = ptr+1 mod WEIGHT.
REQ-016 SHALL output per lane sum_next >> L (arithmetic shift, floor rounding, when SIGNED=1; logical when 0), truncated to CW bits.
REQ-017 SHALL keep fill counter count, 0..WEIGHT, incremented per accept, saturating at WEIGHT; shared by all lanes.
REQ-018 SHALL drive m_axis_tuser = 1 when count after the accept equals WEIGHT.
REQ-019 SHALL copy s_axis_tlast to m_axis_tlast with its beat.
REQ-020 SHALL, when CLEAR_ON_LAST=1 and the accepted beat has tlast, compute that beat normally, then set sum=0, count=0, ptr=0 for the next beat; history contents are don't-care (masked by count).
REQ-021 SHALL, when CLEAR_ON_LAST=0, ignore tlast except for passthrough.
REQ-022 SHALL have no internal overflow: sum width covers WEIGHT*max lane magnitude.

Reset
REQ-023 SHALL, while arst=1 at a clock edge, set m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, sum=0, count=0, ptr=0.
REQ-024 SHALL drop an in-flight output beat when arst asserts mid-operation; no beat is accepted in a cycle with arst=1.
REQ-025 SHALL leave the history array unreset (masked by count=0).

Structure
REQ-026 SHALL place no typedefs in a shared package; lane width and sum width are localparams derived from the parameters.
REQ-027 SHALL implement one sub-module, boxcar_lane (history, sum, shift for one lane), instantiated CHANNELS times by a generate loop; handshake, count, ptr and tlast/tuser logic in the top.

Verification
REQ-028 SHALL cover: BUS_WIDTH=2, CHANNELS=1, WEIGHT=4, SIGNED=0, inputs 4,8,12,16,20 -> outputs 1,3,6,10,14, tuser 0,0,0,1,1.
REQ-029 SHALL cover: CHANNELS=2, WEIGHT=2, SIGNED=1, lane0 -3,-3, lane1 5,7 -> lane0 -2,-3, lane1 2,6.
REQ-030 SHALL cover: WEIGHT=4, CLEAR_ON_LAST=1, inputs 100,100,100(tlast),8 -> 25,50,75(tlast),2; tuser all 0.
REQ-031 SHALL cover: m_axis_tready low 3 cycles with output valid -> s_axis_tready low 3 cycles, m_axis_tdata unchanged, no beat lost or duplicated.
REQ-032 SHALL cover: arst high 1 cycle after 3 beats of 40 (WEIGHT=4) -> m_axis_tvalid=0, then input 4 -> output 1, tuser 0.
REQ-033 SHALL cover: 1000 random beats with random tvalid/tready, CHANNELS=4 -> every output matches a reference model.

Source files
------------

// File: rtl/axis_boxcar_average_pkg.sv
// Shared helpers for the AXI-Stream boxcar averager.
// Only constant functions live here; widths are derived per module.
package axis_boxcar_average_pkg;

  function automatic int log2w(input int w);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/boxcar_lane.sv
// One lane of the boxcar: sample history, running sum, scaled output.
// The output is the post-update sum with the low L bits dropped.
module boxcar_lane #(
  parameter int CW     = 8,
  parameter int L      = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  input  logic          full,
  input  logic [L-1:0]  ptr,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] avg
);

  localparam int SW    = CW + L;
  localparam int DEPTH = 1 << L;

  logic [CW-1:0] hist [DEPTH];
  logic [CW-1:0] old;
  logic [SW-1:0] sum;
  logic [SW-1:0] sum_next;
  logic [SW-1:0] add;
  logic [SW-1:0] sub;

  always_comb begin
    old = full ? hist[ptr] : '0;
    add = SIGNED ? {{L{din[CW-1]}}, din}
                 : {{L{1'b0}}, din};
    sub = SIGNED ? {{L{old[CW-1]}}, old}
                 : {{L{1'b0}}, old};
    sum_next = sum + add - sub;
  end

  // Top CW bits equal floor(sum/2^L) for both signednesses.
  assign avg = sum_next[SW-1:L];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (en) begin
      sum <= clear ? '0 : sum_next;
    end
  end

  always_ff @(posedge clk) begin
    if (en) hist[ptr] <= din;
  end

endmodule

// File: rtl/axis_boxcar_average.sv
// AXI-Stream moving average over WEIGHT samples, per packed lane.
// Single output register; one output beat per accepted input beat.
module axis_boxcar_average
  import axis_boxcar_average_pkg::*;
#(
  parameter int BUS_WIDTH     = 2,
  parameter int CHANNELS      = 1,
  parameter int WEIGHT        = 8,
  parameter int SIGNED        = 0,
  parameter int CLEAR_ON_LAST = 1
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser
);

  localparam int DW    = BUS_WIDTH * 8;
  localparam int CW    = DW / CHANNELS;
  localparam int L     = log2w(WEIGHT);
  localparam int CNT_W = L + 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [L-1:0]     ptr;
  logic [DW-1:0]    avg_bus;
  logic             accept;
  logic             full;
  logic             clear;

  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign accept = s_axis_tvalid & s_axis_tready & ~arst;
  assign full   = (count == CNT_W'(WEIGHT));
  assign clear  = (CLEAR_ON_LAST != 0) & s_axis_tlast;
  assign count_next = full ? count : count + 1'b1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    boxcar_lane #(
      .CW     (CW),
      .L      (L),
      .SIGNED (SIGNED != 0)
    ) u_lane (
      .clk   (aclk),
      .rst   (arst),
      .en    (accept),
      .clear (clear),
      .full  (full),
      .ptr   (ptr),
      .din   (s_axis_tdata[g*CW +: CW]),
      .avg   (avg_bus[g*CW +: CW])
    );
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      count         <= '0;
      ptr           <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= avg_bus;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= (count_next == CNT_W'(WEIGHT));
      // Pointer wraps by width since WEIGHT is a power of two.
      count <= clear ? '0 : count_next;
      ptr   <= clear ? '0 : ptr + 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_boxcar_average.sv
// Bench for axis_boxcar_average: directed cases on small configs,
// plus a randomized 4-lane run scored against a windowed-mean model.
module tb_axis_boxcar_average;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // u0: 1 lane, unsigned, WEIGHT=4, clear on last
  logic [15:0] a_sdata, a_mdata;
  logic a_svalid, a_sready, a_slast;
  logic a_mvalid, a_mready, a_mlast, a_muser;

  axis_boxcar_average #(
    .BUS_WIDTH(2), .CHANNELS(1), .WEIGHT(4),
    .SIGNED(0), .CLEAR_ON_LAST(1)
  ) u0 (
    .aclk(clk), .arst(arst),
    .s_axis_tdata(a_sdata), .s_axis_tvalid(a_svalid),
    .s_axis_tready(a_sready), .s_axis_tlast(a_slast),
    .m_axis_tdata(a_mdata), .m_axis_tvalid(a_mvalid),
    .m_axis_tready(a_mready), .m_axis_tlast(a_mlast),
    .m_axis_tuser(a_muser)
  );

  // u1: 2 lanes, signed, WEIGHT=2
  logic [15:0] b_sdata, b_mdata;
  logic b_svalid, b_sready, b_slast;
  logic b_mvalid, b_mready, b_mlast, b_muser;

  axis_boxcar_average #(
    .BUS_WIDTH(2), .CHANNELS(2), .WEIGHT(2),
    .SIGNED(1), .CLEAR_ON_LAST(1)
  ) u1 (
    .aclk(clk), .arst(arst),
    .s_axis_tdata(b_sdata), .s_axis_tvalid(b_svalid),
    .s_axis_tready(b_sready), .s_axis_tlast(b_slast),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid),
    .m_axis_tready(b_mready), .m_axis_tlast(b_mlast),
    .m_axis_tuser(b_muser)
  );

  // u2: 4 signed byte lanes, WEIGHT=8, clear on last
  logic [31:0] c_sdata, c_mdata;
  logic c_svalid, c_sready, c_slast;
  logic c_mvalid, c_mready, c_mlast, c_muser;

  axis_boxcar_average #(
    .BUS_WIDTH(4), .CHANNELS(4), .WEIGHT(8),
    .SIGNED(1), .CLEAR_ON_LAST(1)
  ) u2 (
    .aclk(clk), .arst(arst),
    .s_axis_tdata(c_sdata), .s_axis_tvalid(c_svalid),
    .s_axis_tready(c_sready), .s_axis_tlast(c_slast),
    .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid),
    .m_axis_tready(c_mready), .m_axis_tlast(c_mlast),
    .m_axis_tuser(c_muser)
  );

  task automatic do_reset();
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic send_a(input string tag, input logic [15:0] d,
                        input logic last, input logic [15:0] exp_d,
                        input logic exp_u);
    a_sdata = d; a_slast = last; a_svalid = 1'b1; a_mready = 1'b1;
    @(negedge clk);
    a_svalid = 1'b0; a_slast = 1'b0;
    check({tag, ".valid"}, a_mvalid, 1);
    check({tag, ".data"}, a_mdata, exp_d);
    check({tag, ".user"}, a_muser, exp_u);
    check({tag, ".last"}, a_mlast, last);
  endtask

  task automatic send_b(input string tag, input logic [15:0] d,
                        input logic [15:0] exp_d, input logic exp_u);
    b_sdata = d; b_svalid = 1'b1;
    @(negedge clk);
    b_svalid = 1'b0;
    check({tag, ".valid"}, b_mvalid, 1);
    check({tag, ".data"}, b_mdata, exp_d);
    check({tag, ".user"}, b_muser, exp_u);
  endtask

  // Reference: per-lane window of the last WEIGHT samples since restart
  int win [4][$];
  logic [31:0] exp_data [$];
  logic        exp_user [$];
  logic        exp_last [$];

  task automatic model_accept(input logic [31:0] d, input logic last);
    logic [31:0] o;
    logic [7:0]  lane;
    int s;
    int q;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      if (win[i].size() == 8) void'(win[i].pop_front());
      lane = d[8*i +: 8];
      win[i].push_back(int'($signed(lane)));
      s = 0;
      for (int k = 0; k < win[i].size(); k++) s += win[i][k];
      q = s / 8;
      if (s % 8 != 0 && s < 0) q = q - 1;
      o[8*i +: 8] = q[7:0];
    end
    exp_data.push_back(o);
    exp_user.push_back(win[0].size() == 8);
    exp_last.push_back(last);
    if (last) begin
      for (int i = 0; i < 4; i++) win[i].delete();
    end
  endtask

  task automatic observe_c();
    if (c_mvalid && c_mready) begin
      if (exp_data.size() == 0) begin
        check("rnd.spurious", 1, 0);
      end else begin
        check("rnd.data", c_mdata, exp_data.pop_front());
        check("rnd.user", c_muser, exp_user.pop_front());
        check("rnd.last", c_mlast, exp_last.pop_front());
      end
    end
    if (c_svalid && c_sready) model_accept(c_sdata, c_slast);
  endtask

  initial begin
    int acc;
    int cyc;
    a_sdata = '0; a_svalid = 1'b0; a_slast = 1'b0; a_mready = 1'b1;
    b_sdata = '0; b_svalid = 1'b0; b_slast = 1'b0; b_mready = 1'b1;
    c_sdata = '0; c_svalid = 1'b0; c_slast = 1'b0; c_mready = 1'b1;
    arst = 1'b1;
    repeat (2) @(negedge clk);
    arst = 1'b0;

    check("rst.valid", a_mvalid, 0);
    check("rst.data", a_mdata, 0);
    check("rst.user", a_muser, 0);
    check("rst.last", a_mlast, 0);
    check("rst.sready", a_sready, 1);

    // Ramp fills the window, then slides
    send_a("ramp0", 16'd4,  1'b0, 16'd1,  1'b0);
    send_a("ramp1", 16'd8,  1'b0, 16'd3,  1'b0);
    send_a("ramp2", 16'd12, 1'b0, 16'd6,  1'b0);
    send_a("ramp3", 16'd16, 1'b0, 16'd10, 1'b1);
    send_a("ramp4", 16'd20, 1'b0, 16'd14, 1'b1);

    // Signed two-lane floor rounding
    send_b("sgn0", 16'h05FD, 16'h02FE, 1'b0);
    send_b("sgn1", 16'h07FD, 16'h06FD, 1'b1);

    // Window restart after tlast
    do_reset();
    send_a("clr0", 16'd100, 1'b0, 16'd25, 1'b0);
    send_a("clr1", 16'd100, 1'b0, 16'd50, 1'b0);
    send_a("clr2", 16'd100, 1'b1, 16'd75, 1'b0);
    send_a("clr3", 16'd8,   1'b0, 16'd2,  1'b0);

    // Reset mid-stream with a held beat and a pending input
    do_reset();
    send_a("pre0", 16'd40, 1'b0, 16'd10, 1'b0);
    send_a("pre1", 16'd40, 1'b0, 16'd20, 1'b0);
    send_a("pre2", 16'd40, 1'b0, 16'd30, 1'b0);
    a_mready = 1'b0; a_svalid = 1'b1; a_sdata = 16'd40;
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0; a_svalid = 1'b0;
    check("midrst.valid", a_mvalid, 0);
    check("midrst.data", a_mdata, 0);
    send_a("post0", 16'd4, 1'b0, 16'd1, 1'b0);

    // Output stall holds data and blocks input
    do_reset();
    a_mready = 1'b0; a_svalid = 1'b1; a_sdata = 16'd40; a_slast = 1'b0;
    @(negedge clk);
    a_sdata = 16'd80;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.sready", a_sready, 0);
      check("stall.valid", a_mvalid, 1);
      check("stall.data", a_mdata, 16'd10);
      @(negedge clk);
    end
    a_mready = 1'b1;
    #1;
    check("stall.release", a_sready, 1);
    @(negedge clk);
    a_svalid = 1'b0;
    check("stall.next.valid", a_mvalid, 1);
    check("stall.next.data", a_mdata, 16'd30);
    @(negedge clk);
    check("stall.drop", a_mvalid, 0);

    // Randomized traffic on the 4-lane instance
    do_reset();
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      c_svalid = ($urandom_range(0, 3) != 0);
      c_sdata  = $urandom;
      c_slast  = ($urandom_range(0, 15) == 0);
      c_mready = ($urandom_range(0, 3) != 0);
      #1;
      if (c_svalid && c_sready) acc++;
      observe_c();
      @(negedge clk);
      cyc++;
    end
    check("rnd.accepted", acc, 1000);
    c_svalid = 1'b0;
    c_mready = 1'b1;
    cyc = 0;
    while (exp_data.size() != 0 && cyc < 20) begin
      #1;
      observe_c();
      @(negedge clk);
      cyc++;
    end
    check("rnd.drained", exp_data.size(), 0);
    check("rnd.idle", c_mvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
